// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Buffers results from two producers (ALU and load/store) in independent
//   FIFOs and broadcasts at most one result per cycle on the common data bus.
//   When both FIFOs hold results, a round-robin priority bit chooses the source.
//   Broadcasts are registered, so there is no bypass from a producer to the bus.
//
// Parameters
//   DATA_W  result data width
//   TAG_W   rename tag width (all-zeros is the free tag)
//   DEPTH   entries per source FIFO (power of 2, at least 2)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global ready; when low every register holds
//   flush               mispredict clear; drops all buffered results
//   alu_valid/tag/data  ALU result input; alu_ready = ALU FIFO not full
//   ls_valid/tag/data   LS result input;  ls_ready  = LS FIFO not full
//   cdb_en/tag/data     registered broadcast (zeros when nothing is granted)
//   cdb_src             source of the broadcast: 0 = ALU, 1 = LS
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ls_valid,
    input  logic [TAG_W-1:0]  ls_tag,
    input  logic [DATA_W-1:0] ls_data,
    output logic              ls_ready,
    output logic              cdb_en,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_src
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Index 0 is the ALU source, index 1 the LS source (matches cdb_src).
    logic   [1:0] valid_in;
    entry_t       in_entry [2];
    entry_t       head     [2];
    logic   [1:0] ready;
    logic   [1:0] nonempty;
    logic   [1:0] push;
    logic   [1:0] pop;
    logic         go;
    logic         pop_en;
    logic         grant_ls;
    logic         prio;

    assign valid_in    = {ls_valid, alu_valid};
    assign in_entry[0] = '{tag: alu_tag, data: alu_data};
    assign in_entry[1] = '{tag: ls_tag,  data: ls_data};
    assign go          = rdy & ~flush;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        entry_t          mem [DEPTH];
        logic [AW-1:0]   wr_ptr;
        logic [AW-1:0]   rd_ptr;
        logic [CW-1:0]   count;

        // Ready depends only on the registered count, so a full FIFO refuses
        // a push even when the same edge pops it.
        assign ready[g]    = count < FULL;
        assign nonempty[g] = count != '0;
        assign push[g]     = go & valid_in[g] & ready[g];
        assign head[g]     = mem[rd_ptr];

        // NOTE: the storage array carries no reset; an entry is only ever read
        // while count says it is valid, and clearing count discards it.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr] <= in_entry[g];
            end
        end

        // NOTE: registers are updated with non-blocking assignments so every
        // always_ff samples the pre-edge value of every other register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (rdy) begin
                if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    // Pointers wrap naturally because DEPTH is a power of 2.
                    if (push[g]) wr_ptr <= wr_ptr + AW'(1);
                    if (pop[g])  rd_ptr <= rd_ptr + AW'(1);
                    if (push[g] && !pop[g]) begin
                        count <= count + CW'(1);
                    end else if (!push[g] && pop[g]) begin
                        count <= count - CW'(1);
                    end
                end
            end
        end
    end

    // Grant selection: a lone non-empty FIFO always wins; with both non-empty
    // the priority bit decides.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        pop_en   = 1'b0;
        grant_ls = 1'b0;
        pop      = 2'b00;
        if (go && (nonempty != 2'b00)) begin
            pop_en   = 1'b1;
            grant_ls = nonempty[1] & (~nonempty[0] | prio);
            pop      = grant_ls ? 2'b10 : 2'b01;
        end
    end

    // Priority only moves on a contested grant, and then points at the loser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                prio <= 1'b0;
            end else if (pop_en && (nonempty == 2'b11)) begin
                prio <= ~grant_ls;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_en   <= 1'b0;
            cdb_tag  <= '0;
            cdb_data <= '0;
            cdb_src  <= 1'b0;
        end else if (rdy) begin
            // pop_en is already low during a flush, so this also zeroes the bus.
            if (pop_en) begin
                cdb_en   <= 1'b1;
                cdb_tag  <= head[grant_ls].tag;
                cdb_data <= head[grant_ls].data;
                cdb_src  <= grant_ls;
            end else begin
                cdb_en   <= 1'b0;
                cdb_tag  <= '0;
                cdb_data <= '0;
                cdb_src  <= 1'b0;
            end
        end
    end

    assign alu_ready = ready[0];
    assign ls_ready  = ready[1];

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter. A queue-based reference model runs on
//   each rising edge and pushes every expected broadcast (stamped with the cycle
//   it must appear in) into a scoreboard; a monitor on the falling edge pops
//   and compares. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        bit                src;
        int                cyc;
    } exp_t;

    typedef struct {
        bit                en;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        bit                src;
    } out_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rdy = 1'b1;
    logic              flush = 1'b0;
    logic              alu_valid = 1'b0;
    logic [TAG_W-1:0]  alu_tag = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              alu_ready;
    logic              ls_valid = 1'b0;
    logic [TAG_W-1:0]  ls_tag = '0;
    logic [DATA_W-1:0] ls_data = '0;
    logic              ls_ready;
    logic              cdb_en;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_src;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_tag   (alu_tag),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ls_valid  (ls_valid),
        .ls_tag    (ls_tag),
        .ls_data   (ls_data),
        .ls_ready  (ls_ready),
        .cdb_en    (cdb_en),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t alu_m[$];
    ent_t ls_m[$];
    exp_t exp_q[$];
    bit   prio_m   = 1'b0;
    bit   rdy_last = 1'b1;
    int   cyc      = 0;
    out_t held     = '{en: 1'b0, tag: '0, data: '0, src: 1'b0};
    logic [TAG_W-1:0] seen[$];

    initial begin
        bit   a_rdy;
        bit   l_rdy;
        bit   pick_ls;
        ent_t r;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                alu_m.delete();
                ls_m.delete();
                exp_q.delete();
                prio_m   = 1'b0;
                rdy_last = 1'b1;
                held     = '{en: 1'b0, tag: '0, data: '0, src: 1'b0};
            end else begin
                cyc++;
                rdy_last = rdy;
                if (rdy) begin
                    if (flush) begin
                        alu_m.delete();
                        ls_m.delete();
                        prio_m = 1'b0;
                    end else begin
                        a_rdy = alu_m.size() < DEPTH;
                        l_rdy = ls_m.size() < DEPTH;
                        if (alu_m.size() > 0 || ls_m.size() > 0) begin
                            if (alu_m.size() == 0)     pick_ls = 1'b1;
                            else if (ls_m.size() == 0) pick_ls = 1'b0;
                            else begin
                                pick_ls = prio_m;
                                prio_m  = !pick_ls;
                            end
                            r = pick_ls ? ls_m.pop_front() : alu_m.pop_front();
                            exp_q.push_back('{tag: r.tag, data: r.data, src: pick_ls, cyc: cyc});
                        end
                        if (alu_valid && a_rdy) alu_m.push_back('{tag: alu_tag, data: alu_data});
                        if (ls_valid && l_rdy)  ls_m.push_back('{tag: ls_tag, data: ls_data});
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdy_last) begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    check("cdb_en", cdb_en, 1);
                    check("cdb_tag", cdb_tag, e.tag);
                    check("cdb_data", cdb_data, e.data);
                    check("cdb_src", cdb_src, e.src);
                    held = '{en: 1'b1, tag: e.tag, data: e.data, src: e.src};
                end else begin
                    check("idle_en", cdb_en, 0);
                    check("idle_tag", cdb_tag, 0);
                    check("idle_data", cdb_data, 0);
                    check("idle_src", cdb_src, 0);
                    held = '{en: 1'b0, tag: '0, data: '0, src: 1'b0};
                end
                if (cdb_en) seen.push_back(cdb_tag);
            end else begin
                check("hold_en", cdb_en, held.en);
                check("hold_tag", cdb_tag, held.tag);
                check("hold_data", cdb_data, held.data);
                check("hold_src", cdb_src, held.src);
            end
            check("alu_ready", alu_ready, alu_m.size() < DEPTH);
            check("ls_ready", ls_ready, ls_m.size() < DEPTH);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        ls_valid  = 1'b0;
        flush     = 1'b0;
        rdy       = 1'b1;
    endtask

    initial begin
        int exp_order[8];
        exp_order = '{1, 5, 2, 6, 3, 7, 4, 8};

        // Reset state.
        repeat (2) step();
        check("rst_en", cdb_en, 0);
        check("rst_tag", cdb_tag, 0);
        check("rst_data", cdb_data, 0);
        check("rst_src", cdb_src, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_ls_ready", ls_ready, 1);
        rst = 1'b0;
        step();

        // Single ALU result: visible one cycle after the accept edge.
        alu_valid = 1'b1; alu_tag = 4'd3; alu_data = 32'h11;
        step();
        alu_valid = 1'b0;
        check("single_not_early", cdb_en, 0);
        step();
        check("single_en", cdb_en, 1);
        check("single_tag", cdb_tag, 3);
        check("single_data", cdb_data, 32'h11);
        check("single_src", cdb_src, 0);
        step();
        check("single_one_cycle", cdb_en, 0);

        // Both sources every cycle for 4 cycles: interleaved order.
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_tag = TAG_W'(i + 1); alu_data = 32'hA000 + i;
            ls_valid  = 1'b1; ls_tag  = TAG_W'(i + 5); ls_data  = 32'hB000 + i;
            check("rr_alu_ready", alu_ready, 1);
            check("rr_ls_ready", ls_ready, 1);
            step();
        end
        idle_inputs();
        repeat (10) step();
        check("rr_count", seen.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < seen.size()) check("rr_order", seen[i], exp_order[i]);
        end

        // Fill LS to DEPTH: ready drops, an extra push is dropped, one pop frees it.
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 7; i++) begin
            alu_valid = 1'b1; alu_tag = TAG_W'(i + 1); alu_data = 32'hC100 + i;
            ls_valid  = 1'b1; ls_tag  = TAG_W'(i + 8); ls_data  = 32'hD100 + i;
            step();
            if (i == 5) check("full_ls_ready_low", ls_ready, 0);
        end
        check("full_ls_ready_back", ls_ready, 1);
        idle_inputs();
        repeat (14) step();

        // Both FIFOs at 3 entries, then flush with a push pending.
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1; alu_tag = TAG_W'(i + 1); alu_data = 32'hE000 + i;
            ls_valid  = 1'b1; ls_tag  = TAG_W'(i + 6); ls_data  = 32'hF000 + i;
            step();
        end
        flush = 1'b1;
        step();
        idle_inputs();
        check("flush_en", cdb_en, 0);
        check("flush_alu_ready", alu_ready, 1);
        check("flush_ls_ready", ls_ready, 1);
        seen.delete();
        repeat (8) step();
        check("flush_no_broadcast", seen.size(), 0);

        // rdy low for 3 cycles while tag 9 is on the bus.
        seen.delete();
        alu_valid = 1'b1; alu_tag = 4'd9;  alu_data = 32'h99;
        step();
        alu_tag = 4'd10; alu_data = 32'hAA;
        step();
        alu_valid = 1'b0;
        check("stall_start_tag", cdb_tag, 9);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_en", cdb_en, 1);
            check("stall_hold_tag", cdb_tag, 9);
        end
        rdy = 1'b1;
        step();
        check("stall_resume_tag", cdb_tag, 10);
        repeat (4) step();
        check("stall_seen", seen.size(), 2);

        // Asynchronous reset between edges with entries buffered.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_tag = TAG_W'(i + 1); alu_data = 32'h500 + i;
            ls_valid  = 1'b1; ls_tag  = TAG_W'(i + 4); ls_data  = 32'h600 + i;
            step();
        end
        idle_inputs();
        check("arst_pre_en", cdb_en, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_en", cdb_en, 0);
        check("arst_alu_ready", alu_ready, 1);
        check("arst_ls_ready", ls_ready, 1);
        #1 rst = 1'b0;
        seen.delete();
        repeat (6) step();
        check("arst_no_broadcast", seen.size(), 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rdy       = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_tag   = TAG_W'($urandom_range(1, 15));
            alu_data  = $urandom;
            ls_valid  = ($urandom_range(0, 9) < 5);
            ls_tag    = TAG_W'($urandom_range(1, 15));
            ls_data   = $urandom;
            step();
        end
        idle_inputs();
        repeat (2 * DEPTH + 6) step();
        check("no_loss", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
